// File: rtl/vector_op_sequencer.sv
// Steps one decoded vector instruction across vl elements, one element per beat,
// handshaking memory elements and stalling fetch while the instruction is in flight.
module vector_op_sequencer #(
  parameter int MAX_VL = 16,
  parameter int IDX_W  = 4,
  parameter int VL_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       OpCode,
  input  logic [VL_W-1:0]  vl,
  input  logic             abort,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             elem_en,
  output logic [IDX_W-1:0] elem_idx,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MEM  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [VL_W-1:0] MAX_VL_V = VL_W'(MAX_VL);

  logic [1:0]       state_q, state_d;
  logic [3:0]       opcode_q, opcode_d;
  logic [VL_W-1:0]  vl_q, vl_d;
  logic [IDX_W-1:0] elem_idx_q, elem_idx_d;

  logic [VL_W-1:0] vl_eff;
  logic            last_elem;
  logic            op_is_mem;
  logic            op_is_alu;
  logic            op_illegal;
  logic            step;

  assign vl_eff     = (vl > MAX_VL_V) ? MAX_VL_V : vl;
  assign last_elem  = (VL_W'(elem_idx_q) == (vl_q - VL_W'(1)));
  assign op_is_mem  = (OpCode >= 4'h4) && (OpCode <= 4'h7);
  assign op_is_alu  = (OpCode >= 4'h8) && (OpCode <= 4'hC);
  assign op_illegal = (opcode_q >= 4'hD);

  // abort outranks both the memory handshake and last-element completion
  assign step = ~abort && ((state_q == S_EXEC) || ((state_q == S_MEM) && mem_ack));

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    vl_d       = vl_q;
    elem_idx_d = elem_idx_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          opcode_d   = OpCode;
          vl_d       = vl_eff;
          elem_idx_d = '0;
          if (vl_eff == '0)   state_d = S_DONE;
          else if (op_is_mem) state_d = S_MEM;
          else if (op_is_alu) state_d = S_EXEC;
          else                state_d = S_DONE;
        end
      end
      S_EXEC, S_MEM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (step) begin
          // hold the index on the last element so it never reaches vl_eff
          if (last_elem) state_d = S_DONE;
          else           elem_idx_d = elem_idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      opcode_q   <= '0;
      vl_q       <= '0;
      elem_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      vl_q       <= vl_d;
      elem_idx_q <= elem_idx_d;
    end
  end

  assign op_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign mem_req  = (state_q == S_MEM);
  assign mem_we   = (state_q == S_MEM) && opcode_q[1];
  assign elem_en  = step;
  assign elem_idx = elem_idx_q;
  assign done     = (state_q == S_DONE) && ~abort;
  assign illegal  = done && op_illegal;

endmodule

// File: tb/tb_vector_op_sequencer.sv
// Directed bench for vector_op_sequencer: expected element/done events go into a
// scoreboard queue, a negedge monitor pops and compares them as the DUT emits.
module tb_vector_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic       op_ready;
  logic [3:0] OpCode;
  logic [4:0] vl;
  logic       abort;
  logic       mem_ack;
  logic       mem_req;
  logic       mem_we;
  logic       elem_en;
  logic [3:0] elem_idx;
  logic       busy;
  logic       done;
  logic       illegal;

  int checks   = 0;
  int failures = 0;

  // event code: {kind[1:0], mem_req/0, mem_we/illegal, idx[3:0]}
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  vector_op_sequencer #(.MAX_VL(16), .IDX_W(4), .VL_W(5)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .OpCode(OpCode), .vl(vl), .abort(abort), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .elem_en(elem_en),
    .elem_idx(elem_idx), .busy(busy), .done(done), .illegal(illegal)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] ev_elem(input logic m, input logic we, input logic [3:0] idx);
    return {2'b01, m, we, idx};
  endfunction

  function automatic logic [7:0] ev_done(input logic ill);
    return {2'b10, 1'b0, ill, 4'h0};
  endfunction

  always @(negedge clk) begin
    logic [7:0] act;
    logic [7:0] e;
    if (!rst && (elem_en || done)) begin
      if (elem_en) act = ev_elem(mem_req, mem_we, elem_idx);
      else         act = ev_done(illegal);
      if (elem_en && done) begin
        checks++;
        failures++;
        $display("FAIL sb_overlap elem_en and done both high");
      end else if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=%0h required=none", act);
      end else begin
        e = exp_q.pop_front();
        check("sb_event", int'(act), int'(e));
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (!op_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=busy required=op_ready", name);
    end
  endtask

  // returns 1ns after the accepting edge
  task automatic issue(input logic [3:0] op, input logic [4:0] len);
    wait_idle("issue");
    op_valid = 1'b1;
    OpCode   = op;
    vl       = len;
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; op_valid = 1'b0; OpCode = 4'h0; vl = 5'd0; abort = 1'b0; mem_ack = 1'b0;
    #3;
    check("rst_op_ready", op_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_outs", {mem_req, mem_we, elem_en, done, illegal}, 0);
    check("rst_idx", elem_idx, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // T1: ALU op, vl=4
    for (int i = 0; i < 4; i++) exp_q.push_back(ev_elem(1'b0, 1'b0, 4'(i)));
    exp_q.push_back(ev_done(1'b0));
    issue(4'h8, 5'd4);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) check("t1_busy", busy, 1);
      if (k == 5) check("t1_done_lat", done, 1);
      if (k == 5) check("t1_not_ready", op_ready, 0);
      if (k == 6) check("t1_ready_lat", op_ready, 1);
    end

    // T2: load, vl=2, each ack two cycles late
    exp_q.push_back(ev_elem(1'b1, 1'b0, 4'd0));
    exp_q.push_back(ev_elem(1'b1, 1'b0, 4'd1));
    exp_q.push_back(ev_done(1'b0));
    issue(4'h4, 5'd2);
    for (int a = 0; a < 2; a++) begin
      repeat (2) begin
        @(negedge clk);
        check("t2_req_held", {mem_req, mem_we, elem_en}, 3'b100);
        @(posedge clk);
      end
      #1 mem_ack = 1'b1;
      @(posedge clk);
      #1 mem_ack = 1'b0;
    end
    @(negedge clk);
    check("t2_done_after_ack", done, 1);

    // T3: store, abort together with the first ack
    issue(4'h6, 5'd3);
    @(posedge clk);
    #1 begin abort = 1'b1; mem_ack = 1'b1; end
    @(negedge clk);
    check("t3_we", mem_we, 1);
    check("t3_no_elem", elem_en, 0);
    @(posedge clk);
    #1 begin abort = 1'b0; mem_ack = 1'b0; end
    @(negedge clk);
    check("t3_idle", {op_ready, busy}, 2'b10);
    repeat (3) @(negedge clk);

    // T4: short ops; the first is accepted with abort held high in IDLE
    exp_q.push_back(ev_done(1'b0));
    wait_idle("t4");
    abort = 1'b1;
    issue(4'h1, 5'd7);
    abort = 1'b0;
    @(negedge clk);
    check("t4_nop_done", done, 1);
    exp_q.push_back(ev_done(1'b0));
    issue(4'h9, 5'd0);
    @(negedge clk);
    check("t4_vl0_done", done, 1);
    exp_q.push_back(ev_done(1'b1));
    issue(4'hE, 5'd3);
    @(negedge clk);
    check("t4_illegal", {done, illegal}, 2'b11);

    // T5: clamp vl=20 to 16, then abort at idx 2
    for (int i = 0; i < 16; i++) exp_q.push_back(ev_elem(1'b0, 1'b0, 4'(i)));
    exp_q.push_back(ev_done(1'b0));
    issue(4'h8, 5'd20);
    exp_q.push_back(ev_elem(1'b0, 1'b0, 4'd0));
    exp_q.push_back(ev_elem(1'b0, 1'b0, 4'd1));
    issue(4'h8, 5'd5);
    @(posedge clk);
    @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    check("t5_abort_idx", elem_idx, 2);
    check("t5_abort_no_elem", elem_en, 0);
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    check("t5_idle", {op_ready, busy}, 2'b10);
    repeat (3) @(negedge clk);

    // T6: async reset mid-MEM
    issue(4'h5, 5'd4);
    @(negedge clk);
    check("t6_in_mem", {mem_req, busy}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_drop", {mem_req, busy, elem_en, done}, 0);
    check("t6_rst_ready", op_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(ev_elem(1'b0, 1'b0, 4'd0));
    exp_q.push_back(ev_done(1'b0));
    issue(4'hA, 5'd1);
    wait_idle("t6");
    repeat (3) @(negedge clk);

    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
